// File: rtl/tl_pkg.sv
// Shared TileLink definitions for the slave-port monitor: opcodes, error codes
// and the beat-count helper used by both channel beat counters.
package tl_pkg;

  localparam logic [2:0] TL_PUTFULL = 3'd0;
  localparam logic [2:0] TL_PUTPART = 3'd1;
  localparam logic [2:0] TL_ARITH   = 3'd2;
  localparam logic [2:0] TL_LOGIC   = 3'd3;
  localparam logic [2:0] TL_GET     = 3'd4;

  localparam logic [2:0] TL_ACK     = 3'd0;
  localparam logic [2:0] TL_ACKDATA = 3'd1;

  typedef enum logic [3:0] {
    TL_ERR_NONE       = 4'd0,
    TL_ERR_A_ILLEGAL  = 4'd1,
    TL_ERR_A_UNSTABLE = 4'd2,
    TL_ERR_D_UNSTABLE = 4'd3,
    TL_ERR_SRC_REUSE  = 4'd4,
    TL_ERR_D_UNEXPECT = 4'd5,
    TL_ERR_D_OPCODE   = 4'd6,
    TL_ERR_OVERFLOW   = 4'd7,
    TL_ERR_A_BURST    = 4'd8,
    TL_ERR_D_BURST    = 4'd9
  } tl_err_e;

  // Wide enough for 2**15 bytes / 4-byte beats.
  typedef logic [15:0] tl_beat_t;

  function automatic tl_beat_t tl_beats(input logic [3:0] size, input logic [3:0] beat_lg);
    tl_beat_t beats;
    if (size > beat_lg) beats = 16'd1 << (size - beat_lg);
    else beats = 16'd1;
    return beats;
  endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// Per-channel burst beat tracker: idle at zero, loaded with beats-1 on the first
// fire of a multi-beat message, decremented on each following fire.
module tl_beat_counter
  import tl_pkg::*;
(
  input  logic     clk,
  input  logic     srst_n,
  input  logic     fire,
  input  tl_beat_t beats,
  output logic     first,
  output logic     last
);

  tl_beat_t count_reg, count_next;

  always_comb begin
    count_next = count_reg;
    if (fire) begin
      if (count_reg == '0) begin
        if (beats > 16'd1) count_next = beats - 16'd1;
      end else begin
        count_next = count_reg - 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) count_reg <= '0;
    else count_reg <= count_next;
  end

  assign first = (count_reg == '0);
  assign last  = first ? (beats <= 16'd1) : (count_reg == 16'd1);

endmodule

// File: rtl/tl_slave_monitor.sv
// Passive TileLink UL/UH slave-port checker: tracks per-source inflight requests
// and bursts, reports violations as a registered pulse plus a sticky first code.
module tl_slave_monitor
  import tl_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RS      = 4,
  parameter int MAX     = 2,
  parameter int ATOMIC  = 0,
  parameter int BURST   = 1,
  parameter int MAXSIZE = 4
) (
  input  logic            slave_clock_i,
  input  logic            slave_resetn_i,
  input  logic [2:0]      slave_a_opcode,
  input  logic [2:0]      slave_a_param,
  input  logic [3:0]      slave_a_size,
  input  logic [RS-1:0]   slave_a_source,
  input  logic [AW-1:0]   slave_a_address,
  input  logic [DW/8-1:0] slave_a_mask,
  input  logic [DW-1:0]   slave_a_data,
  input  logic            slave_a_corrupt,
  input  logic            slave_a_valid,
  input  logic            slave_a_ready,
  input  logic [2:0]      slave_d_opcode,
  input  logic [1:0]      slave_d_param,
  input  logic [3:0]      slave_d_size,
  input  logic [RS-1:0]   slave_d_source,
  input  logic            slave_d_denied,
  input  logic [DW-1:0]   slave_d_data,
  input  logic            slave_d_corrupt,
  input  logic            slave_d_valid,
  input  logic            slave_d_ready,
  output logic [RS:0]     outstanding_o,
  output logic            err_o,
  output logic [3:0]      err_code_o,
  output logic            err_sticky_o
);

  localparam int NSRC  = 2 ** RS;
  localparam int CNT_W = RS + 1;
  localparam int AF_W  = 3 + 3 + 4 + RS + AW + DW / 8 + DW + 1;
  localparam int DF_W  = 3 + 2 + 4 + RS + 1 + DW + 1;
  localparam int AH_W  = 3 + 3 + 4 + RS + AW;
  localparam int DH_W  = 3 + 4 + RS + 1;
  localparam logic [3:0]       BEAT_LG_L = 4'($clog2(DW / 8));
  localparam logic [3:0]       MAXSIZE_L = 4'(MAXSIZE);
  localparam logic [CNT_W-1:0] MAX_L     = CNT_W'(MAX);

  logic a_fire, d_fire;
  logic a_first, a_last, d_first, d_last;
  tl_beat_t a_beats, d_beats;

  assign a_fire = slave_a_valid & slave_a_ready;
  assign d_fire = slave_d_valid & slave_d_ready;

  always_comb begin
    a_beats = 16'd1;
    d_beats = 16'd1;
    if (slave_a_opcode == TL_PUTFULL || slave_a_opcode == TL_PUTPART)
      a_beats = tl_beats(slave_a_size, BEAT_LG_L);
    if (slave_d_opcode == TL_ACKDATA)
      d_beats = tl_beats(slave_d_size, BEAT_LG_L);
  end

  tl_beat_counter u_a_beats (
    .clk(slave_clock_i), .srst_n(slave_resetn_i), .fire(a_fire),
    .beats(a_beats), .first(a_first), .last(a_last)
  );

  tl_beat_counter u_d_beats (
    .clk(slave_clock_i), .srst_n(slave_resetn_i), .fire(d_fire),
    .beats(d_beats), .first(d_first), .last(d_last)
  );

  // Stalled-beat snapshots for the stability checks.
  logic [AF_W-1:0] a_bus, a_bus_reg;
  logic [DF_W-1:0] d_bus, d_bus_reg;
  logic            a_stall_reg, d_stall_reg;

  assign a_bus = {slave_a_opcode, slave_a_param, slave_a_size, slave_a_source, slave_a_address,
                  slave_a_mask, slave_a_data, slave_a_corrupt};
  assign d_bus = {slave_d_opcode, slave_d_param, slave_d_size, slave_d_source, slave_d_denied,
                  slave_d_data, slave_d_corrupt};

  always_ff @(posedge slave_clock_i) begin
    if (!slave_resetn_i) begin
      a_stall_reg <= 1'b0;
      d_stall_reg <= 1'b0;
      a_bus_reg   <= '0;
      d_bus_reg   <= '0;
    end else begin
      a_stall_reg <= slave_a_valid & ~slave_a_ready;
      d_stall_reg <= slave_d_valid & ~slave_d_ready;
      a_bus_reg   <= a_bus;
      d_bus_reg   <= d_bus;
    end
  end

  // Burst hold registers capture the header of each first beat.
  logic [AH_W-1:0] a_head, a_hold_reg;
  logic [DH_W-1:0] d_head, d_hold_reg;
  logic            a_set, d_clr;

  assign a_head = {slave_a_opcode, slave_a_param, slave_a_size, slave_a_source, slave_a_address};
  assign d_head = {slave_d_opcode, slave_d_size, slave_d_source, slave_d_denied};
  assign a_set  = a_fire & a_first;
  assign d_clr  = d_fire & d_last;

  always_ff @(posedge slave_clock_i) begin
    if (!slave_resetn_i) begin
      a_hold_reg <= '0;
      d_hold_reg <= '0;
    end else begin
      if (a_set) a_hold_reg <= a_head;
      if (d_fire && d_first) d_hold_reg <= d_head;
    end
  end

  // Per-source inflight state; an A set wins over a same-cycle D clear.
  logic       pending_reg     [NSRC];
  logic       expect_data_reg [NSRC];
  logic [3:0] size_reg        [NSRC];
  logic       a_wants_data;

  assign a_wants_data = (slave_a_opcode == TL_GET) || (slave_a_opcode == TL_ARITH) ||
                        (slave_a_opcode == TL_LOGIC);

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_slot
    always_ff @(posedge slave_clock_i) begin
      if (!slave_resetn_i) begin
        pending_reg[gi]     <= 1'b0;
        expect_data_reg[gi] <= 1'b0;
        size_reg[gi]        <= '0;
      end else if (a_set && slave_a_source == RS'(gi)) begin
        pending_reg[gi]     <= 1'b1;
        expect_data_reg[gi] <= a_wants_data;
        size_reg[gi]        <= slave_a_size;
      end else if (d_clr && slave_d_source == RS'(gi)) begin
        pending_reg[gi]     <= 1'b0;
      end
    end
  end

  logic [CNT_W-1:0] out_reg, out_next;

  always_comb begin
    out_next = out_reg;
    if (a_set && !d_clr) begin
      if (out_reg != {CNT_W{1'b1}}) out_next = out_reg + 1'b1;
    end else if (!a_set && d_clr) begin
      if (out_reg != '0) out_next = out_reg - 1'b1;
    end
  end

  logic a_is_atomic, a_op_ok, a_size_bad, a_misalign;
  logic a_illegal, a_unstable, d_unstable, src_reuse, d_unexpect, d_opcode_err;
  logic overflow, a_burst_err, d_burst_err;
  logic [2:0] d_exp_op;

  assign a_is_atomic = (slave_a_opcode == TL_ARITH) || (slave_a_opcode == TL_LOGIC);
  assign a_op_ok     = (slave_a_opcode == TL_PUTFULL) || (slave_a_opcode == TL_PUTPART) ||
                       (slave_a_opcode == TL_GET) || ((ATOMIC != 0) && a_is_atomic);
  assign a_size_bad  = (BURST != 0) ? (slave_a_size > MAXSIZE_L) : (slave_a_size > BEAT_LG_L);
  assign a_misalign  = |(slave_a_address & ~({AW{1'b1}} << slave_a_size));
  assign a_illegal   = slave_a_valid && (!a_op_ok || a_size_bad || a_misalign ||
                                         (a_is_atomic && slave_a_size > BEAT_LG_L));

  assign a_unstable  = a_stall_reg && (!slave_a_valid || a_bus != a_bus_reg);
  assign d_unstable  = d_stall_reg && (!slave_d_valid || d_bus != d_bus_reg);

  assign src_reuse   = a_set && pending_reg[slave_a_source] &&
                       !(d_clr && slave_d_source == slave_a_source);
  assign d_unexpect  = d_fire && d_first && !pending_reg[slave_d_source];
  assign d_exp_op    = expect_data_reg[slave_d_source] ? TL_ACKDATA : TL_ACK;
  assign d_opcode_err = d_fire && pending_reg[slave_d_source] &&
                        (slave_d_opcode != d_exp_op || slave_d_size != size_reg[slave_d_source]);
  assign overflow    = a_set && !d_clr && (out_reg >= MAX_L);
  assign a_burst_err = a_fire && !a_first && (a_head != a_hold_reg);
  assign d_burst_err = d_fire && !d_first && (d_head != d_hold_reg);

  logic [9:0] err_vec;
  tl_err_e    err_code_next, err_code_reg;
  logic       err_reg, err_sticky_reg;

  assign err_vec = {d_burst_err, a_burst_err, overflow, d_opcode_err, d_unexpect,
                    src_reuse, d_unstable, a_unstable, a_illegal, 1'b0};

  // Scanning downwards leaves the lowest-numbered active code.
  always_comb begin
    err_code_next = TL_ERR_NONE;
    for (int i = 9; i >= 1; i--) begin
      if (err_vec[i]) err_code_next = tl_err_e'(4'(i));
    end
  end

  always_ff @(posedge slave_clock_i) begin
    if (!slave_resetn_i) begin
      out_reg        <= '0;
      err_reg        <= 1'b0;
      err_code_reg   <= TL_ERR_NONE;
      err_sticky_reg <= 1'b0;
    end else begin
      out_reg <= out_next;
      err_reg <= |err_vec;
      if (|err_vec && !err_sticky_reg) begin
        err_code_reg   <= err_code_next;
        err_sticky_reg <= 1'b1;
      end
    end
  end

  assign outstanding_o = out_reg;
  assign err_o         = err_reg;
  assign err_code_o    = err_code_reg;
  assign err_sticky_o  = err_sticky_reg;

endmodule

// File: tb/tb_tl_slave_monitor.sv
// Directed vectors and burst/reset sequences for the TileLink slave monitor.
module tb_tl_slave_monitor;

  logic        clk;
  logic        resetn;
  logic [2:0]  a_opcode, a_param;
  logic [3:0]  a_size;
  logic [3:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        a_corrupt, a_valid, a_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic [3:0]  d_source;
  logic        d_denied;
  logic [31:0] d_data;
  logic        d_corrupt, d_valid, d_ready;
  logic [4:0]  outstanding;
  logic        err;
  logic [3:0]  err_code;
  logic        err_sticky;

  int checks = 0;
  int errors = 0;

  tl_slave_monitor #(
    .AW(32), .DW(32), .RS(4), .MAX(2), .ATOMIC(0), .BURST(1), .MAXSIZE(4)
  ) dut (
    .slave_clock_i(clk), .slave_resetn_i(resetn),
    .slave_a_opcode(a_opcode), .slave_a_param(a_param), .slave_a_size(a_size),
    .slave_a_source(a_source), .slave_a_address(a_address), .slave_a_mask(a_mask),
    .slave_a_data(a_data), .slave_a_corrupt(a_corrupt), .slave_a_valid(a_valid),
    .slave_a_ready(a_ready),
    .slave_d_opcode(d_opcode), .slave_d_param(d_param), .slave_d_size(d_size),
    .slave_d_source(d_source), .slave_d_denied(d_denied), .slave_d_data(d_data),
    .slave_d_corrupt(d_corrupt), .slave_d_valid(d_valid), .slave_d_ready(d_ready),
    .outstanding_o(outstanding), .err_o(err), .err_code_o(err_code),
    .err_sticky_o(err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        av, ar;
    logic [2:0]  aop;
    logic [3:0]  asz, asrc;
    logic [31:0] aaddr;
    logic        dv, dr;
    logic [2:0]  dop;
    logic [3:0]  dsz, dsrc;
    logic [4:0]  eout;
    logic        eerr;
    logic [3:0]  ecode;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic av, input logic ar,
                              input logic [2:0] aop, input logic [3:0] asz,
                              input logic [3:0] asrc, input logic [31:0] aaddr,
                              input logic dv, input logic dr, input logic [2:0] dop,
                              input logic [3:0] dsz, input logic [3:0] dsrc,
                              input logic [4:0] eout, input logic eerr,
                              input logic [3:0] ecode);
    vec_t v;
    v.rst = rst; v.av = av; v.ar = ar; v.aop = aop; v.asz = asz; v.asrc = asrc;
    v.aaddr = aaddr; v.dv = dv; v.dr = dr; v.dop = dop; v.dsz = dsz; v.dsrc = dsrc;
    v.eout = eout; v.eerr = eerr; v.ecode = ecode;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic drive_a(input logic av, input logic ar, input logic [2:0] op,
                         input logic [3:0] sz, input logic [3:0] src, input logic [31:0] addr);
    a_valid = av; a_ready = ar; a_opcode = op; a_size = sz; a_source = src; a_address = addr;
  endtask

  task automatic drive_d(input logic dv, input logic dr, input logic [2:0] op,
                         input logic [3:0] sz, input logic [3:0] src);
    d_valid = dv; d_ready = dr; d_opcode = op; d_size = sz; d_source = src;
  endtask

  task automatic expect_state(input string tag, input logic [4:0] eout, input logic eerr,
                              input logic [3:0] ecode, input logic esticky);
    $display("%s: out=%0d err=%0b code=%0d sticky=%0b", tag, outstanding, err, err_code, err_sticky);
    check({tag, " outstanding"}, 32'(outstanding), 32'(eout));
    check({tag, " err_o"}, 32'(err), 32'(eerr));
    check({tag, " err_code"}, 32'(err_code), 32'(ecode));
    check({tag, " sticky"}, 32'(err_sticky), 32'(esticky));
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    drive_a(0, 0, 3'd0, 4'd0, 4'd0, 32'h0);
    drive_d(0, 0, 3'd0, 4'd0, 4'd0);
    step();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    a_param = 3'd0; a_mask = 4'hF; a_data = 32'h0; a_corrupt = 1'b0;
    d_param = 2'd0; d_denied = 1'b0; d_data = 32'h0; d_corrupt = 1'b0;
    drive_a(0, 0, 3'd0, 4'd0, 4'd0, 32'h0);
    drive_d(0, 0, 3'd0, 4'd0, 4'd0);

    //                rst av ar aop  asz  asrc aaddr     dv dr dop  dsz  dsrc  out err code
    vecs.push_back(mk(1, 0, 0, 3'd0, 4'd0, 4'd0, 32'h0,   0, 0, 3'd0, 4'd0, 4'd0, 5'd0, 0, 4'd0)); // reset
    vecs.push_back(mk(0, 1, 1, 3'd4, 4'd2, 4'd3, 32'h40,  0, 0, 3'd0, 4'd0, 4'd0, 5'd1, 0, 4'd0)); // Get src3
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 4'd0, 32'h0,   1, 1, 3'd1, 4'd2, 4'd3, 5'd0, 0, 4'd0)); // AckData src3
    vecs.push_back(mk(0, 1, 1, 3'd4, 4'd2, 4'd5, 32'h80,  0, 0, 3'd0, 4'd0, 4'd0, 5'd1, 0, 4'd0)); // Get src5
    vecs.push_back(mk(0, 1, 1, 3'd4, 4'd2, 4'd5, 32'h80,  0, 0, 3'd0, 4'd0, 4'd0, 5'd2, 1, 4'd4)); // reuse src5
    vecs.push_back(mk(0, 1, 1, 3'd4, 4'd2, 4'd6, 32'h84,  0, 0, 3'd0, 4'd0, 4'd0, 5'd3, 1, 4'd4)); // overflow, sticky
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 4'd0, 32'h0,   0, 0, 3'd0, 4'd0, 4'd0, 5'd3, 0, 4'd4)); // idle
    vecs.push_back(mk(1, 0, 0, 3'd0, 4'd0, 4'd0, 32'h0,   0, 0, 3'd0, 4'd0, 4'd0, 5'd0, 0, 4'd0)); // reset
    vecs.push_back(mk(0, 1, 0, 3'd4, 4'd2, 4'd1, 32'h100, 0, 0, 3'd0, 4'd0, 4'd0, 5'd0, 0, 4'd0)); // stall
    vecs.push_back(mk(0, 1, 0, 3'd4, 4'd2, 4'd1, 32'h104, 0, 0, 3'd0, 4'd0, 4'd0, 5'd0, 1, 4'd2)); // addr moved
    vecs.push_back(mk(0, 1, 1, 3'd4, 4'd2, 4'd1, 32'h104, 0, 0, 3'd0, 4'd0, 4'd0, 5'd1, 0, 4'd2)); // held, fires
    vecs.push_back(mk(1, 0, 0, 3'd0, 4'd0, 4'd0, 32'h0,   0, 0, 3'd0, 4'd0, 4'd0, 5'd0, 0, 4'd0)); // reset
    vecs.push_back(mk(0, 1, 1, 3'd4, 4'd2, 4'd2, 32'h0,   0, 0, 3'd0, 4'd0, 4'd0, 5'd1, 0, 4'd0)); // Get src2
    vecs.push_back(mk(0, 1, 1, 3'd4, 4'd2, 4'd2, 32'h0,   1, 1, 3'd1, 4'd2, 4'd2, 5'd1, 0, 4'd0)); // reissue + ack
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 4'd0, 32'h0,   1, 1, 3'd1, 4'd2, 4'd2, 5'd0, 0, 4'd0)); // ack reissue
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 4'd0, 32'h0,   1, 1, 3'd1, 4'd2, 4'd2, 5'd0, 1, 4'd5)); // unexpected, sat 0
    vecs.push_back(mk(1, 0, 0, 3'd0, 4'd0, 4'd0, 32'h0,   0, 0, 3'd0, 4'd0, 4'd0, 5'd0, 0, 4'd0)); // reset
    vecs.push_back(mk(0, 1, 1, 3'd0, 4'd2, 4'd1, 32'h0,   0, 0, 3'd0, 4'd0, 4'd0, 5'd1, 0, 4'd0)); // PutFull src1
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 4'd0, 32'h0,   1, 1, 3'd1, 4'd2, 4'd1, 5'd0, 1, 4'd6)); // wrong D opcode
    vecs.push_back(mk(1, 0, 0, 3'd0, 4'd0, 4'd0, 32'h0,   0, 0, 3'd0, 4'd0, 4'd0, 5'd0, 0, 4'd0)); // reset
    vecs.push_back(mk(0, 1, 0, 3'd5, 4'd2, 4'd0, 32'h0,   0, 0, 3'd0, 4'd0, 4'd0, 5'd0, 1, 4'd1)); // bad opcode
    vecs.push_back(mk(0, 1, 0, 3'd5, 4'd2, 4'd0, 32'h0,   0, 0, 3'd0, 4'd0, 4'd0, 5'd0, 1, 4'd1)); // still bad
    vecs.push_back(mk(1, 0, 0, 3'd0, 4'd0, 4'd0, 32'h0,   0, 0, 3'd0, 4'd0, 4'd0, 5'd0, 0, 4'd0)); // reset
    vecs.push_back(mk(0, 1, 1, 3'd4, 4'd2, 4'd0, 32'h2,   0, 0, 3'd0, 4'd0, 4'd0, 5'd1, 1, 4'd1)); // misaligned
    vecs.push_back(mk(1, 0, 0, 3'd0, 4'd0, 4'd0, 32'h0,   0, 0, 3'd0, 4'd0, 4'd0, 5'd0, 0, 4'd0)); // reset
    vecs.push_back(mk(0, 1, 1, 3'd0, 4'd5, 4'd0, 32'h0,   0, 0, 3'd0, 4'd0, 4'd0, 5'd1, 1, 4'd1)); // size > MAXSIZE
    vecs.push_back(mk(1, 0, 0, 3'd0, 4'd0, 4'd0, 32'h0,   0, 0, 3'd0, 4'd0, 4'd0, 5'd0, 0, 4'd0)); // reset
    vecs.push_back(mk(0, 1, 1, 3'd4, 4'd4, 4'd0, 32'h10,  0, 0, 3'd0, 4'd0, 4'd0, 5'd1, 0, 4'd0)); // Get size=MAXSIZE
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 4'd0, 32'h0,   1, 1, 3'd1, 4'd4, 4'd0, 5'd1, 0, 4'd0)); // D beat 1/4
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 4'd0, 32'h0,   1, 1, 3'd1, 4'd4, 4'd0, 5'd1, 0, 4'd0)); // D beat 2/4
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 4'd0, 32'h0,   1, 1, 3'd1, 4'd4, 4'd0, 5'd1, 0, 4'd0)); // D beat 3/4
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 4'd0, 32'h0,   1, 1, 3'd1, 4'd4, 4'd0, 5'd0, 0, 4'd0)); // D beat 4/4
    vecs.push_back(mk(1, 0, 0, 3'd0, 4'd0, 4'd0, 32'h0,   0, 0, 3'd0, 4'd0, 4'd0, 5'd0, 0, 4'd0)); // reset
    vecs.push_back(mk(0, 1, 1, 3'd4, 4'd2, 4'd1, 32'h0,   0, 0, 3'd0, 4'd0, 4'd0, 5'd1, 0, 4'd0)); // Get src1
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 4'd0, 32'h0,   1, 0, 3'd1, 4'd2, 4'd1, 5'd1, 0, 4'd0)); // D stall
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 4'd0, 32'h0,   1, 1, 3'd1, 4'd3, 4'd1, 5'd1, 1, 4'd3)); // D size moved

    foreach (vecs[i]) begin
      resetn = ~vecs[i].rst;
      drive_a(vecs[i].av, vecs[i].ar, vecs[i].aop, vecs[i].asz, vecs[i].asrc, vecs[i].aaddr);
      drive_d(vecs[i].dv, vecs[i].dr, vecs[i].dop, vecs[i].dsz, vecs[i].dsrc);
      step();
      expect_state($sformatf("vec[%0d]", i), vecs[i].eout, vecs[i].eerr, vecs[i].ecode,
                   vecs[i].ecode != 4'd0);
    end

    // 4-beat PutFullData whose third beat moves the address.
    do_reset();
    drive_a(1, 1, 3'd0, 4'd4, 4'd1, 32'h100); step();
    expect_state("burst beat1", 5'd1, 0, 4'd0, 0);
    step();
    expect_state("burst beat2", 5'd1, 0, 4'd0, 0);
    drive_a(1, 1, 3'd0, 4'd4, 4'd1, 32'h110); step();
    expect_state("burst beat3", 5'd1, 1, 4'd8, 1);
    drive_a(1, 1, 3'd0, 4'd4, 4'd1, 32'h100); step();
    expect_state("burst beat4", 5'd1, 0, 4'd8, 1);
    drive_a(0, 0, 3'd0, 4'd0, 4'd0, 32'h0);
    drive_d(1, 1, 3'd0, 4'd4, 4'd1); step();
    expect_state("burst ack", 5'd0, 0, 4'd8, 1);

    // Reset in the middle of a 4-beat AccessAckData, then a clean exchange.
    drive_d(0, 0, 3'd0, 4'd0, 4'd0);
    do_reset();
    drive_a(1, 1, 3'd4, 4'd4, 4'd7, 32'h0); step();
    expect_state("midrst get", 5'd1, 0, 4'd0, 0);
    drive_a(0, 0, 3'd0, 4'd0, 4'd0, 32'h0);
    drive_d(1, 1, 3'd1, 4'd4, 4'd7); step();
    step();
    expect_state("midrst beat2", 5'd1, 0, 4'd0, 0);
    do_reset();
    expect_state("midrst reset", 5'd0, 0, 4'd0, 0);
    drive_a(1, 1, 3'd4, 4'd2, 4'd7, 32'h0); step();
    expect_state("midrst reget", 5'd1, 0, 4'd0, 0);
    drive_a(0, 0, 3'd0, 4'd0, 4'd0, 32'h0);
    drive_d(1, 1, 3'd1, 4'd2, 4'd7); step();
    expect_state("midrst ack", 5'd0, 0, 4'd0, 0);
    drive_d(0, 0, 3'd0, 4'd0, 4'd0); step();
    expect_state("midrst idle", 5'd0, 0, 4'd0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
